amo_reservation_unit: RTL and testbench
=======================================

Name: amo_reservation_unit

Overview:
- Tracks the single LR/SC reservation for the load-store unit's atomic path. Consumes the AMO_UNIT configuration (LR_WAIT, RESERVATION_WORDS).
- Sits beside the LS unit, downstream of decode/issue.
- Records the reservation granule on LR and ages it for LR_WAIT cycles. Kills it on a matching external invalidation.
- Resolves every SC to pass or fail one cycle after presentation.

Parameters:
- LR_WAIT, 32, cycles a reservation stays valid after LR; must be >= 1.
- RESERVATION_WORDS, 8, 32-bit words per reservation granule; power of two, >= 1; equals the DCACHE LINE_W when a data cache is present.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-low; rst=0 at a rising edge resets the block.
- lr_valid  in  1  LR issued this cycle.
- lr_addr  in  32  LR byte address.
- sc_valid  in  1  SC issued this cycle.
- sc_addr  in  32  SC byte address.
- inv_valid  in  1  external invalidation this cycle.
- inv_addr  in  32  invalidation byte address.
- sc_done  out  1  one-cycle pulse carrying the SC result.
- sc_success  out  1  SC result; valid only when sc_done=1.
- reservation_valid  out  1  a reservation is currently held.
- reservation_granule  out  32-G  reserved granule, where G=2+$clog2(RESERVATION_WORDS).

Behaviour:
- Granule of an address: addr[31:G]. Reset value of every output is 0.
- Registered state:
  - res_valid.
  - res_granule.
  - counter, width $clog2(LR_WAIT+1).
  - sc_done_r and sc_success_r.
- States: IDLE (res_valid=0) and RESERVED (res_valid=1).
- Age counter in RESERVED:
  - Decrements by 1 each cycle.
  - When counter==1 and no new LR arrives, next state is IDLE and the counter goes to 0.
- LR at cycle t:
  - Next state is RESERVED, res_granule <= lr_addr granule, counter <= LR_WAIT.
  - reservation_valid is 1 for exactly cycles t+1 .. t+LR_WAIT.
  - An LR while already RESERVED replaces the granule and restarts the counter.
- SC at cycle t:
  - sc_done=1 at t+1.
  - sc_success=1 iff, in cycle t, res_valid=1, sc_addr granule == res_granule, and there is no same-cycle inv_valid whose granule matches res_granule.
  - An SC always clears the reservation: IDLE at t+1, pass or fail.
- Invalidation: inv_valid with a matching granule while RESERVED gives IDLE next cycle. A non-matching granule has no effect. Invalidation while IDLE is ignored.
- Simultaneous events:
  - lr_valid and sc_valid in the same cycle are illegal. The LS unit guarantees exclusivity; the bench asserts it.
  - LR with inv in the same cycle: the inv is checked against the old reservation only. The new LR reservation is always established.
  - SC in the last valid cycle (counter==1): evaluated against the still-valid reservation, so success is possible.
  - SC with a non-matching inv: the inv has no effect on the result.
- Local stores do not affect the reservation; there is no store port.
- sc_done / sc_success are registered, fixed 1-cycle latency, no backpressure. Back-to-back SCs yield back-to-back pulses.
- Reset mid-operation:
  - State returns to IDLE; counter, granule, sc_done and sc_success are cleared.
  - An SC presented in the reset cycle produces no sc_done.

Test Plan (LR_WAIT=32, RESERVATION_WORDS=8, G=5):
- LR 0x80000040 at t0; SC 0x8000005C at t0+5 -> sc_done=1, sc_success=1 at t0+6; reservation_valid=0 from t0+6.
- LR 0x80000040; SC 0x80000060 at t0+3 -> sc_success=0, sc_done=1; reservation cleared.
- LR 0x80000040 at t0:
  - reservation_valid=1 for t0+1..t0+32.
  - SC 0x80000040 at t0+32 -> success=1.
  - Repeat with the SC at t0+33 -> success=0.
- LR 0x80000040; inv 0x80000044 at t0+2 -> reservation_valid=0 at t0+3; SC at t0+4 fails.
- LR 0x80000040; inv 0x80000044 and SC 0x80000040 in the same cycle -> fail.
- LR 0x80000040, then LR 0x80001000 -> reservation_granule=0x80001000>>5; SC 0x80000040 -> fail.
- LR 0x80000040, then rst=0 for one cycle at t0+4 -> all outputs 0 at t0+5; SC 0x80000040 at t0+6 -> success=0.

Source files
------------

// File: rtl/amo_reservation_unit_if.sv
// amo_reservation_unit_if: LR/SC/invalidate requests and reservation status between the LS unit and the reservation tracker
interface amo_reservation_unit_if #(
  parameter int RESERVATION_WORDS = 8
);
  localparam int G = 2 + $clog2(RESERVATION_WORDS);
  logic lr_valid;
  logic [31:0] lr_addr;
  logic sc_valid;
  logic [31:0] sc_addr;
  logic inv_valid;
  logic [31:0] inv_addr;
  logic sc_done;
  logic sc_success;
  logic reservation_valid;
  logic [31-G:0] reservation_granule;
  modport master (
    output lr_valid, lr_addr, sc_valid, sc_addr, inv_valid, inv_addr,
    input sc_done, sc_success, reservation_valid, reservation_granule
  );
  modport slave (
    input lr_valid, lr_addr, sc_valid, sc_addr, inv_valid, inv_addr,
    output sc_done, sc_success, reservation_valid, reservation_granule
  );
endinterface

// File: rtl/amo_reservation_unit.sv
// amo_reservation_unit: single LR/SC reservation with LR_WAIT aging, invalidation kill and 1-cycle SC resolution
module amo_reservation_unit #(
  parameter int LR_WAIT = 32,
  parameter int RESERVATION_WORDS = 8
) (
  input logic clk,
  input logic rst,
  amo_reservation_unit_if.slave bus
);
  localparam int G = 2 + $clog2(RESERVATION_WORDS);
  localparam int CW = $clog2(LR_WAIT + 1);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RESERVED = 1'b1;
  logic [0:0] state;
  logic [31-G:0] granule;
  logic [CW-1:0] counter;
  logic sc_done_r;
  logic sc_success_r;
  logic inv_hit;
  logic sc_hit;
  // A matching invalidation in the SC's own cycle wins over the SC.
  always_comb begin
    inv_hit = state == RESERVED && bus.inv_valid && bus.inv_addr[31:G] == granule;
    sc_hit = state == RESERVED && bus.sc_addr[31:G] == granule && !inv_hit;
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      granule <= '0;
      counter <= '0;
      sc_done_r <= 1'b0;
      sc_success_r <= 1'b0;
    end else begin
      sc_done_r <= bus.sc_valid;
      sc_success_r <= bus.sc_valid && sc_hit;
      if (bus.lr_valid) begin
        state <= RESERVED;
        granule <= bus.lr_addr[31:G];
        counter <= CW'(LR_WAIT);
      end else if (state == RESERVED && (bus.sc_valid || inv_hit || counter == CW'(1))) begin
        state <= IDLE;
        counter <= '0;
      end else if (state == RESERVED) begin
        counter <= counter - 1'b1;
      end
    end
  end
  assign bus.sc_done = sc_done_r;
  assign bus.sc_success = sc_success_r;
  assign bus.reservation_valid = state == RESERVED;
  assign bus.reservation_granule = granule;
endmodule

// File: tb/tb_amo_reservation_unit.sv
// tb_amo_reservation_unit: directed test-plan scenarios plus random traffic against an expiry-time reference model
module tb_amo_reservation_unit;
  localparam int LW = 32;
  localparam int G = 5;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int compared = 0;
  int mismatched = 0;
  bit chk_en = 1'b0;
  amo_reservation_unit_if #(.RESERVATION_WORDS(8)) bus ();
  amo_reservation_unit #(.LR_WAIT(LW), .RESERVATION_WORDS(8)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  // Reference: a reservation is alive until an absolute edge number, not a down-counter.
  int edge_no = 0;
  bit alive = 1'b0;
  int expire = 0;
  logic [31-G:0] m_gran = '0;
  bit m_done = 1'b0;
  bit m_succ = 1'b0;
  always @(posedge clk) begin
    automatic bit v = alive && edge_no <= expire;
    automatic bit ih = v && bus.inv_valid && bus.inv_addr[31:G] == m_gran;
    assert (!(bus.lr_valid && bus.sc_valid)) else $error("lr and sc issued together");
    edge_no = edge_no + 1;
    m_done = rst && bus.sc_valid;
    m_succ = m_done && v && bus.sc_addr[31:G] == m_gran && !ih;
    if (!rst) begin
      alive = 1'b0;
      m_gran = '0;
    end else if (bus.lr_valid) begin
      alive = 1'b1;
      m_gran = bus.lr_addr[31:G];
      expire = edge_no + LW - 1;
    end else if (bus.sc_valid || ih || !v) begin
      alive = 1'b0;
    end
  end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  always @(negedge clk) if (chk_en) begin
    chk("sc_done", 32'(bus.sc_done), 32'(m_done));
    chk("sc_success", 32'(bus.sc_success), 32'(m_succ));
    chk("reservation_valid", 32'(bus.reservation_valid), 32'(alive && edge_no <= expire));
    chk("reservation_granule", 32'(bus.reservation_granule), 32'(m_gran));
  end
  task automatic cyc(input bit r, input bit lr, input logic [31:0] la, input bit sc,
                     input logic [31:0] sa, input bit inv, input logic [31:0] ia);
    rst = r;
    bus.lr_valid = lr;
    bus.lr_addr = la;
    bus.sc_valid = sc;
    bus.sc_addr = sa;
    bus.inv_valid = inv;
    bus.inv_addr = ia;
    @(posedge clk);
    #1;
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1, 0, 0, 0, 0, 0, 0);
  endtask
  task automatic lr(input logic [31:0] a);
    cyc(1, 1, a, 0, 0, 0, 0);
  endtask
  task automatic sc(input logic [31:0] a);
    cyc(1, 0, 0, 1, a, 0, 0);
  endtask
  initial begin
    cyc(0, 0, 0, 0, 0, 0, 0);
    chk_en = 1'b1;
    cyc(0, 0, 0, 0, 0, 0, 0);
    chk("rst_done", 32'(bus.sc_done), 0);
    chk("rst_valid", 32'(bus.reservation_valid), 0);
    chk("rst_granule", 32'(bus.reservation_granule), 0);
    lr(32'h8000_0040);
    idle(4);
    sc(32'h8000_005C);
    chk("t1_done", 32'(bus.sc_done), 1);
    chk("t1_success", 32'(bus.sc_success), 1);
    chk("t1_valid", 32'(bus.reservation_valid), 0);
    lr(32'h8000_0040);
    idle(2);
    sc(32'h8000_0060);
    chk("t2_done", 32'(bus.sc_done), 1);
    chk("t2_success", 32'(bus.sc_success), 0);
    chk("t2_valid", 32'(bus.reservation_valid), 0);
    lr(32'h8000_0040);
    idle(31);
    chk("t3_last_valid", 32'(bus.reservation_valid), 1);
    sc(32'h8000_0040);
    chk("t3_last_success", 32'(bus.sc_success), 1);
    lr(32'h8000_0040);
    idle(32);
    chk("t3_expired", 32'(bus.reservation_valid), 0);
    sc(32'h8000_0040);
    chk("t3_late_done", 32'(bus.sc_done), 1);
    chk("t3_late_success", 32'(bus.sc_success), 0);
    lr(32'h8000_0040);
    idle(1);
    cyc(1, 0, 0, 0, 0, 1, 32'h8000_0044);
    chk("t4_killed", 32'(bus.reservation_valid), 0);
    idle(1);
    sc(32'h8000_0040);
    chk("t4_success", 32'(bus.sc_success), 0);
    lr(32'h8000_0040);
    cyc(1, 0, 0, 1, 32'h8000_0040, 1, 32'h8000_0044);
    chk("t5_success", 32'(bus.sc_success), 0);
    lr(32'h8000_0040);
    lr(32'h8000_1000);
    chk("t6_granule", 32'(bus.reservation_granule), 32'h8000_1000 >> 5);
    sc(32'h8000_0040);
    chk("t6_success", 32'(bus.sc_success), 0);
    lr(32'h8000_0040);
    idle(3);
    cyc(0, 0, 0, 0, 0, 0, 0);
    chk("t7_valid", 32'(bus.reservation_valid), 0);
    chk("t7_granule", 32'(bus.reservation_granule), 0);
    idle(1);
    sc(32'h8000_0040);
    chk("t7_done", 32'(bus.sc_done), 1);
    chk("t7_success", 32'(bus.sc_success), 0);
    lr(32'h8000_0040);
    cyc(0, 0, 0, 1, 32'h8000_0040, 0, 0);
    chk("rst_sc_done", 32'(bus.sc_done), 0);
    lr(32'h8000_0040);
    sc(32'h8000_0040);
    sc(32'h8000_0040);
    chk("b2b_done", 32'(bus.sc_done), 1);
    chk("b2b_success", 32'(bus.sc_success), 0);
    for (int i = 0; i < 4000; i++) begin
      automatic int op = $urandom_range(0, 99);
      automatic logic [31:0] la = {27'h400_0000 + 27'($urandom_range(0, 3)), 5'($urandom)};
      automatic logic [31:0] sa = {27'h400_0000 + 27'($urandom_range(0, 3)), 5'($urandom)};
      automatic logic [31:0] ia = {27'h400_0000 + 27'($urandom_range(0, 3)), 5'($urandom)};
      cyc(op != 0, op >= 1 && op < 4, la, op >= 4 && op < 12, sa, $urandom_range(0, 7) == 0, ia);
    end
    idle(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
